// File: rtl/fetch_decode_queue_if.sv
// Handshake bundle between instruction fetch, the fetch/decode queue and decode.
// The queue connects through the slave modport; the fetch/decode side uses master.
interface fetch_decode_queue_if #(
    parameter int DEPTH = 2
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    // Valid/ready: a transfer happens on a rising edge where both valid and
    // ready are high and iFlush is low; ready never depends on the same-cycle
    // valid or ready of the opposite side.
    logic          iValid;
    logic [31:0]   iInstr;
    logic [31:0]   iPC;
    logic          oReady;
    logic          oValid;
    logic [31:0]   oInstr;
    logic [31:0]   oPC;
    logic          iReady;
    logic          iFlush;
    logic [CW-1:0] oCount;
    logic [31:0]   oStallCount;

    modport slave (
        input  iValid, iInstr, iPC, iReady, iFlush,
        output oReady, oValid, oInstr, oPC, oCount, oStallCount
    );

    modport master (
        output iValid, iInstr, iPC, iReady, iFlush,
        input  oReady, oValid, oInstr, oPC, oCount, oStallCount
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular elastic buffer of instruction/PC pairs between fetch and decode, with flush.
// Optional decode-stall cycle counter enabled by defining FDQ_STALL_CNT_EN.
module fetch_decode_queue #(
    parameter int DEPTH = 2
) (
    input logic            iClk,
    input logic            iRstN,
    fetch_decode_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h00000013;

    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc    [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full/empty come only from the registered count, so a full queue refuses
    // a push even in a cycle where decode drains the head.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.iValid && !w_full && !bus.iFlush;
    assign w_pop   = !w_empty && bus.iReady && !bus.iFlush;

    assign bus.oReady = !w_full;
    assign bus.oValid = !w_empty;
    assign bus.oCount = r_count;
    assign bus.oInstr = w_empty ? NOP   : r_instr[r_rd_ptr];
    assign bus.oPC    = w_empty ? '0    : r_pc[r_rd_ptr];

    always_ff @(posedge iClk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= bus.iInstr;
            r_pc[r_wr_ptr]    <= bus.iPC;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.iFlush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

`ifdef FDQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Survives flush on purpose: it measures decode back-pressure since reset.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_stall_cnt <= '0;
        end else if (!w_empty && !bus.iReady && !bus.iFlush) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.oStallCount = r_stall_cnt;
`else
    assign bus.oStallCount = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed stimulus, scoreboard queue, negedge monitor.
module tb_fetch_decode_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_decode_queue #(.DEPTH(DEPTH)) dut (.iClk(clk), .iRstN(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];
  int m_count = 0;
  logic [31:0] m_stall = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A0_0013;
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bus.iValid = v;
    bus.iInstr = instr;
    bus.iPC    = pc;
    bus.iReady = rdy;
    bus.iFlush = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the queue contents and occupancy the DUT should hold.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = 0;
      exp_q.delete();
      m_stall = '0;
    end else begin
      logic m_push, m_pop;
      m_push = bus.iValid && (m_count != DEPTH) && !bus.iFlush;
      m_pop  = (m_count != 0) && bus.iReady && !bus.iFlush;
`ifdef FDQ_STALL_CNT_EN
      if ((m_count != 0) && !bus.iReady && !bus.iFlush) m_stall = m_stall + 32'd1;
`endif
      if (bus.iFlush) begin
        m_count = 0;
        exp_q.delete();
      end else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) exp_q.push_back({bus.iPC, bus.iInstr});
        m_count = m_count + int'(m_push) - int'(m_pop);
      end
    end
  end

  // Monitor: every cycle, outputs must match the model head and occupancy.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 64'(bus.oCount), 64'(m_count));
      chk("ready", 64'(bus.oReady), 64'(m_count != DEPTH));
      chk("valid", 64'(bus.oValid), 64'(m_count != 0));
      chk("stall_cnt", 64'(bus.oStallCount), 64'(m_stall));
      if (m_count == 0) begin
        chk("empty_instr", 64'(bus.oInstr), 64'(NOP));
        chk("empty_pc", 64'(bus.oPC), 64'd0);
      end else if (exp_q.size() != 0) begin
        chk("head", {bus.oPC, bus.oInstr}, exp_q[0]);
      end
    end
  end

  initial begin
    int sent;
    int k;
    bus.iValid = 1'b0;
    bus.iInstr = '0;
    bus.iPC    = '0;
    bus.iReady = 1'b0;
    bus.iFlush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(bus.oValid), 64'd0);
    chk("reset_ready", 64'(bus.oReady), 64'd1);
    chk("reset_instr", 64'(bus.oInstr), 64'(NOP));
    rst_n = 1'b1;

    // Idle after reset
    repeat (3) drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Single pass-through
    drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    chk("pass_valid", 64'(bus.oValid), 64'd1);
    chk("pass_data", {bus.oPC, bus.oInstr}, {32'h100, 32'h00500093});
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("pass_gone", 64'(bus.oValid), 64'd0);

    // Fill while decode stalls
    for (int i = 0; i < DEPTH; i++) drive(1'b1, instr_of(32'(i * 4)), 32'(i * 4), 1'b0, 1'b0);
    chk("fill_count", 64'(bus.oCount), 64'd4);
    chk("fill_ready", 64'(bus.oReady), 64'd0);
    drive(1'b1, instr_of(32'h10), 32'h10, 1'b0, 1'b0);
    chk("full_refuse", 64'(bus.oCount), 64'd4);
    // Full with simultaneous pop: pop only
    drive(1'b1, instr_of(32'h10), 32'h10, 1'b1, 1'b0);
    chk("full_pop_count", 64'(bus.oCount), 64'd3);
    chk("full_pop_head", 64'(bus.oPC), 64'h4);
    drive(1'b1, instr_of(32'h10), 32'h10, 1'b1, 1'b0);
    chk("retry_count", 64'(bus.oCount), 64'd3);
    chk("retry_head", 64'(bus.oPC), 64'h8);
    repeat (4) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("drained", 64'(bus.oValid), 64'd0);

    // Flush with push and pop presented
    drive(1'b1, instr_of(32'h40), 32'h40, 1'b0, 1'b0);
    drive(1'b1, instr_of(32'h44), 32'h44, 1'b0, 1'b0);
    drive(1'b1, instr_of(32'h48), 32'h48, 1'b1, 1'b1);
    chk("flush_valid", 64'(bus.oValid), 64'd0);
    chk("flush_count", 64'(bus.oCount), 64'd0);
    chk("flush_ready", 64'(bus.oReady), 64'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (2) drive(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-operation
    drive(1'b1, instr_of(32'h80), 32'h80, 1'b0, 1'b0);
    drive(1'b1, instr_of(32'h84), 32'h84, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.oValid), 64'd0);
    chk("arst_count", 64'(bus.oCount), 64'd0);
    chk("arst_pc", 64'(bus.oPC), 64'd0);
    chk("arst_stall", 64'(bus.oStallCount), 64'd0);
    bus.iValid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Stream 10 entries with iReady low on cycles 3, 4 and 7
    sent = 0;
    k = 0;
    while (sent < 10 && k < 40) begin
      logic acc;
      acc = (m_count != DEPTH);
      drive(1'b1, instr_of(32'(sent * 4)), 32'(sent * 4), !(k == 3 || k == 4 || k == 7), 1'b0);
      if (acc) sent++;
      k++;
    end
    chk("stream_sent", 64'(sent), 64'd10);
    chk("stream_cycles", 64'(k), 64'd11);
    repeat (6) drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("stream_drained", 64'(bus.oValid), 64'd0);
`ifdef FDQ_STALL_CNT_EN
    chk("stall_total", 64'(bus.oStallCount), 64'd3);
`else
    chk("stall_total", 64'(bus.oStallCount), 64'd0);
`endif
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Elastic buffer between instruction fetch and the decode stage; the decode stage's immediate decoder and control decoder take its head entry. It holds DEPTH fetched instruction/PC pairs with valid/ready handshakes on both sides, so instruction-memory latency and decode stalls do not stall each other. It also supports a single-cycle flush for redirects from taken branches and jumps.

## Interface
- DEPTH, 2, entry count; power of two, 2..8
- iClk  in  1  clock, rising edge
- iRstN  in  1  asynchronous active-low reset
- iValid  in  1  fetch presents iInstr/iPC
- iInstr  in  32  fetched instruction word
- iPC  in  32  address of iInstr
- oReady  out  1  queue can accept (not full)
- oValid  out  1  head entry valid
- oInstr  out  32  head instruction; 32'h00000013 (NOP) when empty
- oPC  out  32  head PC; 0 when empty
- iReady  in  1  decode consumes head
- iFlush  in  1  discard all entries (redirect)
- oCount  out  $clog2(DEPTH)+1  occupancy
- oStallCount  out  32  decode-stall cycle counter (see Configuration)

## Operation
- Push = iValid && oReady && !iFlush. Pop = oValid && iReady && !iFlush.
- Storage is a circular buffer with write and read pointers of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH. Occupancy is held in a separate counter of $clog2(DEPTH)+1 bits.
- oValid = (count != 0). oReady = (count != DEPTH).
- oReady depends on registered state only. It has no combinational path from iReady, so a full queue refuses a push even in a cycle where it pops.
- oInstr/oPC: mux of the entry at the read pointer when oValid = 1, otherwise the NOP/0 values. These outputs are combinational from registered state only.
- Simultaneous push and pop (count between 1 and DEPTH-1): write to the write pointer, advance both pointers, count unchanged.
- Simultaneous push and pop when count = 0: impossible, because oValid = 0 so no pop can occur. The push lands and count becomes 1.
- Flush: on the next edge, pointers and count go to 0. Any push or pop presented in the flush cycle is ignored. Storage contents need not be cleared.
- Flush while empty: no effect beyond holding zero state.
- iValid or iReady asserted with the opposite side's flag low: no state change on that side.

## Timing
- Reset (asynchronous, iRstN low) gives:
  - count = 0, pointers = 0
  - oValid = 0, oReady = 1
  - oInstr = 32'h00000013, oPC = 0, oCount = 0
  - oStallCount = 0
- Latency: an entry pushed at edge N is visible on oValid/oInstr/oPC after edge N (one cycle, no bypass).
- Throughput: one push and one pop per cycle in steady state.
- oCount updates at the edge following the handshake. After a flush edge, oValid = 0 and oReady = 1.
- Reset asserted mid-operation takes effect immediately, regardless of clock. All in-flight entries are lost.

## Configuration
- FDQ_STALL_CNT_EN defined:
  - oStallCount increments by 1 on every edge where oValid && !iReady && !iFlush.
  - It wraps from 2^32-1 to 0.
  - It is cleared only by reset, not by flush.
- FDQ_STALL_CNT_EN undefined: oStallCount is tied to 0 and no counter register is built.

## Test plan
- Reset then idle:
  - Stimulus: iRstN low, then high, iValid = 0.
  - Required: oValid = 0, oReady = 1, oInstr = 32'h00000013, oPC = 0, oCount = 0 on every cycle.
- Single pass-through (iReady = 1):
  - Stimulus: push iInstr = 32'h00500093, iPC = 32'h100.
  - Required: the next cycle shows oValid = 1 with the same values; the cycle after shows oValid = 0.
- Fill and stall (DEPTH = 2, iReady = 0):
  - Stimulus: push PCs 0x0 and 0x4, then present 0x8.
  - Required: oReady = 0 and oCount = 2; 0x8 is not accepted.
  - Then raise iReady: oPC sequence is 0x0, 0x4, then 0x8 is accepted once oReady returns to 1.
- Full with simultaneous pop (DEPTH = 2):
  - Stimulus: count = 2, iValid = 1, iReady = 1 for one cycle.
  - Required: pop occurs, push is refused, count becomes 1.
- Flush:
  - Stimulus: count = 2, assert iFlush together with iValid = 1 and iReady = 1.
  - Required: next cycle oValid = 0, oCount = 0, oReady = 1; neither the pushed nor the popped entry is observed afterwards.
- Wrap-around and stall counter (FDQ_STALL_CNT_EN defined):
  - Stimulus: stream 10 entries through DEPTH = 4 with iReady low on 3 cycles while oValid = 1.
  - Required: in-order PCs 0x0..0x24, and oStallCount = 3.
